// File: rtl/cosim_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cosim_stream_pkg
//  Description : Types and helpers shared by the cosim byte-lane serializer
//                and its matching deserializer.
//                  cosim_byte_t       - one byte on the transport lane
//                  cosim_ser_state_e  - serializer FSM states
//                  cosim_num_bytes()  - bytes needed for a message of N bits
//  Revision    : 1.0 - initial release
// ============================================================================
package cosim_stream_pkg;

   typedef logic [7:0] cosim_byte_t;

   typedef enum logic [0:0] {
      CS_IDLE = 1'b0,
      CS_SEND = 1'b1
   } cosim_ser_state_e;

   // Number of whole bytes needed to carry 'bits' bits (last byte may be partial).
   function automatic int cosim_num_bytes(int bits);
      return (bits + 7) / 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cosim_msg_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : cosim_msg_byte_serializer
//  Description : Transmit side of the cosim byte-lane encoding. Accepts one
//                packed TYPE_SIZE_BITS message per valid/ready handshake and
//                emits it byte 0 first (byte i = bits [8i+7:8i]), flagging the
//                final byte with ByteOutLast. The final partial byte carries
//                the leftover message bits in its LSBs with zero padding.
//  Ports       :
//    clk           in   1               clock
//    rstn          in   1               synchronous reset, active-low
//    MsgInValid    in   1               input message valid
//    MsgInReady    out  1               input message ready
//    MsgIn         in   TYPE_SIZE_BITS  packed input message
//    ByteOutValid  out  1               output byte valid
//    ByteOutReady  in   1               output byte ready
//    ByteOut       out  8               output byte
//    ByteOutLast   out  1               high on the final byte of a message
//    ByteOutIdx    out  IDX_W           byte index within the current message
//    MsgCount      out  32              completed message count (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module cosim_msg_byte_serializer
   import cosim_stream_pkg::*;
#(
   parameter  int TYPE_SIZE_BITS = 32,
   localparam int NUM_BYTES      = cosim_num_bytes(TYPE_SIZE_BITS),
   localparam int IDX_W          = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      MsgInValid,
   output logic                      MsgInReady,
   input  logic [TYPE_SIZE_BITS-1:0] MsgIn,
   output logic                      ByteOutValid,
   input  logic                      ByteOutReady,
   output cosim_byte_t               ByteOut,
   output logic                      ByteOutLast,
   output logic [IDX_W-1:0]          ByteOutIdx,
   output logic [31:0]               MsgCount
);

   localparam int               c_HOLD_W   = NUM_BYTES * 8;
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_BYTES - 1);

   if (TYPE_SIZE_BITS < 1) begin : g_bad_width
      $error("cosim_msg_byte_serializer: TYPE_SIZE_BITS must be >= 1");
   end

   cosim_ser_state_e      r_state;
   cosim_ser_state_e      w_state_nxt;
   logic [c_HOLD_W-1:0]   r_hold;
   logic [c_HOLD_W-1:0]   w_hold_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [31:0]           r_count;
   logic [31:0]           w_count_nxt;

   logic                  w_send;
   logic                  w_last;
   logic [c_HOLD_W-1:0]   w_hold_shift;

   // ------------------------------------------------------------------------
   // Output decode: everything below depends only on registered state,
   // except MsgInReady which must see ByteOutReady to allow gapless messages.
   // ------------------------------------------------------------------------
   assign w_send = (r_state == CS_SEND);
   // Gated by SEND so a single-byte message width does not show last while idle.
   assign w_last = w_send && (r_idx == c_LAST_IDX);

   // Byte mux: select hold[8*idx +: 8] by shifting the holding register.
   assign w_hold_shift = r_hold >> {r_idx, 3'b000};

   assign ByteOutValid = w_send;
   assign ByteOut      = w_hold_shift[7:0];
   assign ByteOutLast  = w_last;
   assign ByteOutIdx   = r_idx;
   assign MsgCount     = r_count;

   // Held low while in reset so nothing upstream believes a transfer happened.
   assign MsgInReady   = rstn && (!w_send || (w_last && ByteOutReady));

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_idx_nxt   = r_idx;
      w_count_nxt = r_count;

      case (r_state)
         CS_IDLE: begin
            if (MsgInValid) begin
               w_hold_nxt  = c_HOLD_W'(MsgIn);
               w_idx_nxt   = '0;
               w_state_nxt = CS_SEND;
            end
         end

         CS_SEND: begin
            if (ByteOutReady) begin
               if (w_last) begin
                  w_count_nxt = r_count + 32'd1;
                  // Ready is high on the last-byte transfer, so a waiting
                  // message is taken here with no idle beat in between.
                  if (MsgInValid) begin
                     w_hold_nxt = c_HOLD_W'(MsgIn);
                     w_idx_nxt  = '0;
                  end else begin
                     w_idx_nxt   = '0;
                     w_state_nxt = CS_IDLE;
                  end
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = CS_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= CS_IDLE;
         r_hold  <= '0;
         r_idx   <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_idx   <= w_idx_nxt;
         r_count <= w_count_nxt;
      end
   end

endmodule
`default_nettype wire
